// File: rtl/aes_job_scheduler_if.sv
// Request, core and response signals of the AES job scheduler.
// slave: scheduler side; master: requesters, AES core and response consumer.
interface aes_job_scheduler_if #(
  parameter int DATA_W = 128
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req0_key;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [DATA_W-1:0] req1_key;
  logic              core_en;
  logic [DATA_W-1:0] core_data_in;
  logic [DATA_W-1:0] core_key_in;
  logic [DATA_W-1:0] core_data_out;
  logic              core_valid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    input  core_data_out, core_valid, rsp_ready,
    output req0_ready, req1_ready,
    output core_en, core_data_in, core_key_in,
    output rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    output core_data_out, core_valid, rsp_ready,
    input  req0_ready, req1_ready,
    input  core_en, core_data_in, core_key_in,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/aes_job_scheduler.sv
// Round-robin two-requester front end for a single AES core.
// Define AES_SCHED_TIMEOUT_EN to abort jobs the core never answers.
//
// state | meaning
// IDLE  | no job; grant a pending requester
// RUN   | core_en high, waiting for core_valid (or timeout)
// RESP  | response held until rsp_ready
module aes_job_scheduler #(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic             AES_clk,
  input  logic             AES_rst,
  aes_job_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic              rr_last;
  logic              job_id;
  logic              gnt_id;
  logic              accept;
  logic              done;
  logic              timeout_hit;
  logic [TO_W-1:0]   cnt;
  logic              core_en_q;
  logic [DATA_W-1:0] core_data_q;
  logic [DATA_W-1:0] core_key_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_id_q;
  logic              rsp_err_q;

`ifdef AES_SCHED_TIMEOUT_EN
  assign timeout_hit = (cnt == TO_LAST);
  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign bus.rsp_err    = 1'b0;
  assign unused_timeout = ^{TO_LAST, cnt, rsp_err_q};
`endif

  always_ff @(posedge AES_clk) begin
    if (AES_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Requester != rr_last wins a tie; a lone requester always wins.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    if (bus.req0_valid && bus.req1_valid) gnt_id = ~rr_last;
    else                                  gnt_id = bus.req1_valid;
    case (state)
      IDLE: begin
        if (!AES_rst && (bus.req0_valid || bus.req1_valid)) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.core_valid || timeout_hit) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      rr_last     <= 1'b1;
      job_id      <= 1'b0;
      cnt         <= '0;
      core_en_q   <= 1'b0;
      core_data_q <= '0;
      core_key_q  <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        core_data_q <= gnt_id ? bus.req1_data : bus.req0_data;
        core_key_q  <= gnt_id ? bus.req1_key  : bus.req0_key;
        job_id      <= gnt_id;
        rr_last     <= gnt_id;
        cnt         <= '0;
        core_en_q   <= 1'b1;
      end
      if (state == RUN && cnt != {TO_W{1'b1}}) cnt <= cnt + 1'b1;
      // core_valid beats a simultaneous timeout
      if (done) begin
        core_en_q  <= 1'b0;
        rsp_id_q   <= job_id;
        rsp_data_q <= bus.core_valid ? bus.core_data_out : '0;
        rsp_err_q  <= ~bus.core_valid;
      end
    end
  end

  assign bus.req0_ready   = accept & ~gnt_id;
  assign bus.req1_ready   = accept &  gnt_id;
  assign bus.core_en      = core_en_q;
  assign bus.core_data_in = core_data_q;
  assign bus.core_key_in  = core_key_q;
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.busy         = (state != IDLE);

endmodule
